ustream_to_bin: RTL

USTREAM_TO_BIN -- requirements
Module: ustream_to_bin

---
 rtl/ustream_pkg.sv | 14 +
 rtl/ustream_to_bin_if.sv | 43 ++++
 rtl/ustream_win_cnt.sv | 38 +++
 rtl/ustream_to_bin.sv | 118 +++++++++++
 4 files changed

// File: rtl/ustream_pkg.sv
// ustream_pkg
//   Shared definitions for the unipolar-bitstream-to-binary converter:
//   the window FSM state encoding and the default window length exponent.
package ustream_pkg;

  // Default window length is 2^DEFAULT_WINDOW_LOG2 enabled samples.
  localparam int DEFAULT_WINDOW_LOG2 = 8;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } ustreamState_e;

endpackage

// File: rtl/ustream_to_bin_if.sv
// ustream_to_bin_if
//   Groups the bitstream input, window control and result handshake of
//   ustream_to_bin.
//   Producer/consumer side (master) drives:
//     in      - unipolar bitstream sample
//     iEn     - current sample is valid
//     iStart  - begin a window
//     iCont   - continuous mode, back-to-back windows
//     iClr    - synchronous abort
//     iReady  - consumer accepts oData
//   Converter side (slave) drives:
//     oData   - count of ones in the last completed window (0..WIN)
//     oValid  - oData holds an unconsumed result
//     oBusy   - a window is being accumulated
//     oDrop   - sticky: a result was overwritten before being consumed
interface ustream_to_bin_if
  import ustream_pkg::*;
#(
  parameter int OUT_W = DEFAULT_WINDOW_LOG2 + 1
);

  logic             in;
  logic             iEn;
  logic             iStart;
  logic             iCont;
  logic             iClr;
  logic             iReady;
  logic [OUT_W-1:0] oData;
  logic             oValid;
  logic             oBusy;
  logic             oDrop;

  modport master (
    output in, iEn, iStart, iCont, iClr, iReady,
    input  oData, oValid, oBusy, oDrop
  );

  modport slave (
    input  in, iEn, iStart, iCont, iClr, iReady,
    output oData, oValid, oBusy, oDrop
  );

endinterface

// File: rtl/ustream_win_cnt.sv
// ustream_win_cnt
//   WINDOW_LOG2-bit sample counter with enable and synchronous clear.
//   Ports:
//     iClk - clock, rising edge
//     iRst - asynchronous active-high reset
//     iEn  - count one sample
//     iClr - synchronous clear, wins over iEn
//     oTc  - terminal count: the counter holds WIN-1, so the next enabled
//            sample is the last one of the window
module ustream_win_cnt
  import ustream_pkg::*;
#(
  parameter int WINDOW_LOG2 = DEFAULT_WINDOW_LOG2
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iEn,
  input  logic iClr,
  output logic oTc
);

  logic [WINDOW_LOG2-1:0] cnt;

  // Natural wrap from WIN-1 to 0 leaves the counter zeroed for the next
  // window without an explicit clear.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      cnt <= '0;
    end else if (iClr) begin
      cnt <= '0;
    end else if (iEn) begin
      cnt <= cnt + WINDOW_LOG2'(1);
    end
  end

  assign oTc = (cnt == '1);

endmodule

// File: rtl/ustream_to_bin.sv
// ustream_to_bin
//   Counts the ones of a unipolar bitstream over a window of
//   WIN = 2^WINDOW_LOG2 enabled samples and presents the count as a binary
//   result with a valid/ready handshake.
//   Ports:
//     iClk - clock, rising edge
//     iRst - asynchronous active-high reset
//     bus  - ustream_to_bin_if slave: bitstream, window control, result
//            handshake, busy and sticky drop flag
//   All interface outputs come straight from registers; the final sample
//   of a window is folded into oData on the same edge that captures it.
module ustream_to_bin
  import ustream_pkg::*;
#(
  parameter int WINDOW_LOG2 = DEFAULT_WINDOW_LOG2,
  parameter int OUT_W       = WINDOW_LOG2 + 1
) (
  input  logic            iClk,
  input  logic            iRst,
  ustream_to_bin_if.slave bus
);

  ustreamState_e    state;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] accNext;
  logic [OUT_W-1:0] dataQ;
  logic             validQ;
  logic             busyQ;
  logic             dropQ;
  logic             cntEn;
  logic             cntClr;
  logic             tc;
  logic             winDone;

  function automatic logic [OUT_W-1:0] addSample(input logic [OUT_W-1:0] a,
                                                 input logic             b);
    return a + OUT_W'(b);
  endfunction

  // Samples count only while accumulating; the iStart edge itself is not a
  // sample, it just clears the counter.
  assign cntEn   = (state == ACC) && bus.iEn;
  assign cntClr  = bus.iClr || ((state == IDLE) && bus.iStart);
  assign winDone = cntEn && tc;
  assign accNext = addSample(acc, bus.in);

  ustream_win_cnt #(
    .WINDOW_LOG2 (WINDOW_LOG2)
  ) uWinCnt (
    .iClk (iClk),
    .iRst (iRst),
    .iEn  (cntEn),
    .iClr (cntClr),
    .oTc  (tc)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state  <= IDLE;
      acc    <= '0;
      dataQ  <= '0;
      validQ <= 1'b0;
      busyQ  <= 1'b0;
      dropQ  <= 1'b0;
    end else if (bus.iClr) begin
      // Abort wins over start and window completion; the last result
      // value is kept but no longer offered.
      state  <= IDLE;
      acc    <= '0;
      validQ <= 1'b0;
      busyQ  <= 1'b0;
      dropQ  <= 1'b0;
    end else begin
      // Consumption; overridden below when a new result loads this edge.
      if (validQ && bus.iReady) begin
        validQ <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (bus.iStart) begin
            state <= ACC;
            acc   <= '0;
            busyQ <= 1'b1;
          end
        end

        ACC: begin
          if (winDone) begin
            dataQ  <= accNext;
            validQ <= 1'b1;
            acc    <= '0;
            if (validQ && !bus.iReady) begin
              dropQ <= 1'b1;
            end
            if (!bus.iCont) begin
              state <= IDLE;
              busyQ <= 1'b0;
            end
          end else if (bus.iEn) begin
            acc <= accNext;
          end
        end

        default: begin
          state <= IDLE;
          busyQ <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oData  = dataQ;
  assign bus.oValid = validQ;
  assign bus.oBusy  = busyQ;
  assign bus.oDrop  = dropQ;

endmodule
